// File: rtl/bcid_sync_controller.sv
// BCID counter sequencer: turns BC-reset strobes into the counter's load pulse,
// checks orbit alignment at each later BCR and tracks lock / misalignment errors.
module bcid_sync_controller #(
  parameter int MAX_BCID   = 3563,
  parameter int ERR_THRESH = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clkTMR,
  input  logic                 resetTMR,
  input  logic                 enableTMR,
  input  logic                 autoResyncTMR,
  input  logic                 bcrTMR,
  input  logic                 clrErrTMR,
  input  logic [11:0]          offsetTMR,
  input  logic [11:0]          BCIDTMR,
  output logic                 rstBCIDTMR,
  output logic                 disTMR,
  output logic                 lockedTMR,
  output logic                 mismatchTMR,
  output logic [ERR_CNT_W-1:0] errCountTMR,
  output logic [1:0]           stateTMR
);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARM      = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_LOST     = 2'd3;

  // The counter loads offset two cycles after the BCR, so a full orbit later it
  // reads offset + MAX_BCID - 1 (wrapped) in the BCR cycle.
  function automatic logic [11:0] expectedBcid(input logic [11:0] off);
    logic [12:0] sum;
    sum = {1'b0, off} + 13'(MAX_BCID - 1);
    if (sum > 13'(MAX_BCID)) sum = sum - 13'(MAX_BCID + 1);
    return sum[11:0];
  endfunction

  function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]  stateReg, stateNext;
  logic [3:0]  consecReg, consecNext;
  logic [1:0]  settleReg, settleNext;
  logic        resync_p0, mismatch_p0;
  logic [11:0] expect_p0;
  logic        offsetValid;
  logic [4:0]  consecInc;

  assign expect_p0   = expectedBcid(offsetTMR);
  assign offsetValid = ({1'b0, offsetTMR} <= 13'(MAX_BCID));
  assign consecInc   = {1'b0, consecReg} + 5'd1;
  assign stateTMR    = stateReg;

  // Stage 0: decode strobes against current state and alignment check
  always_comb begin
    stateNext   = stateReg;
    consecNext  = consecReg;
    settleNext  = (settleReg != 2'd0) ? settleReg - 2'd1 : 2'd0;
    resync_p0   = 1'b0;
    mismatch_p0 = 1'b0;
    if (!enableTMR) begin
      stateNext  = ST_DISABLED;
      consecNext = 4'd0;
      settleNext = 2'd0;
    end else begin
      case (stateReg)
        ST_DISABLED: stateNext = ST_ARM;
        ST_ARM: begin
          if (bcrTMR && offsetValid) begin
            resync_p0  = 1'b1;
            stateNext  = ST_LOCKED;
            consecNext = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (bcrTMR) begin
            if (settleReg != 2'd0) begin
              // BCR while the counter is still loading: restart, do not judge
              resync_p0 = offsetValid;
            end else if (BCIDTMR != expect_p0) begin
              mismatch_p0 = 1'b1;
              if (consecInc >= 5'(ERR_THRESH)) begin
                consecNext = 4'd0;
                if (autoResyncTMR && offsetValid) resync_p0 = 1'b1;
                else if (autoResyncTMR)           stateNext = ST_ARM;
                else                              stateNext = ST_LOST;
              end else begin
                consecNext = consecInc[3:0];
              end
            end else begin
              consecNext = 4'd0;
            end
          end
        end
        ST_LOST: begin
          if (clrErrTMR) begin
            stateNext  = ST_ARM;
            consecNext = 4'd0;
          end
        end
        default: stateNext = ST_DISABLED;
      endcase
    end
    if (resync_p0) settleNext = 2'd2;
  end

  // Stage 1: registered outputs and state
  always_ff @(posedge clkTMR or negedge resetTMR) begin
    if (!resetTMR) begin
      stateReg    <= ST_DISABLED;
      consecReg   <= 4'd0;
      settleReg   <= 2'd0;
      rstBCIDTMR  <= 1'b1;
      disTMR      <= 1'b1;
      lockedTMR   <= 1'b0;
      mismatchTMR <= 1'b0;
      errCountTMR <= '0;
    end else begin
      stateReg    <= stateNext;
      consecReg   <= consecNext;
      settleReg   <= settleNext;
      rstBCIDTMR  <= ~resync_p0;
      disTMR      <= (stateNext == ST_DISABLED);
      lockedTMR   <= (stateNext == ST_LOCKED) && !resync_p0;
      mismatchTMR <= mismatch_p0;
      if (clrErrTMR)        errCountTMR <= '0;
      else if (mismatch_p0) errCountTMR <= satInc(errCountTMR);
    end
  end

endmodule

// File: tb/tb_bcid_sync_controller.sv
// Directed bench for bcid_sync_controller with a behavioural BCID counter in the loop.
module tb_bcid_sync_controller;

  logic        clkTMR = 1'b0;
  logic        resetTMR;
  logic        enableTMR;
  logic        autoResyncTMR;
  logic        bcrTMR;
  logic        clrErrTMR;
  logic [11:0] offsetTMR;
  logic [11:0] BCIDTMR;
  logic        rstBCIDTMR;
  logic        disTMR;
  logic        lockedTMR;
  logic        mismatchTMR;
  logic [7:0]  errCountTMR;
  logic [1:0]  stateTMR;

  int compared   = 0;
  int mismatched = 0;

  bcid_sync_controller #(.MAX_BCID(3563), .ERR_THRESH(3), .ERR_CNT_W(8)) dut (
    .clkTMR(clkTMR), .resetTMR(resetTMR), .enableTMR(enableTMR),
    .autoResyncTMR(autoResyncTMR), .bcrTMR(bcrTMR), .clrErrTMR(clrErrTMR),
    .offsetTMR(offsetTMR), .BCIDTMR(BCIDTMR), .rstBCIDTMR(rstBCIDTMR),
    .disTMR(disTMR), .lockedTMR(lockedTMR), .mismatchTMR(mismatchTMR),
    .errCountTMR(errCountTMR), .stateTMR(stateTMR)
  );

  always #5 clkTMR = ~clkTMR;

  // Counter being sequenced: loads offset on the low pulse, holds while disabled.
  always @(posedge clkTMR or negedge resetTMR) begin
    if (!resetTMR)        BCIDTMR <= 12'd0;
    else if (!rstBCIDTMR) BCIDTMR <= offsetTMR;
    else if (!disTMR)     BCIDTMR <= (BCIDTMR >= 12'd3563) ? 12'd0 : BCIDTMR + 12'd1;
  end

  typedef struct {
    int gap; int bcr; int clr; int en; int au; int off; int expBcid;
    int rst; int dis; int lck; int mm; int err; int st;
  } vec_t;

  localparam int X = -1;
  localparam int NVEC = 33;
  localparam int SPLIT = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(int gap, int bcr, int clr, int en, int au, int off, int eb,
                              int rst, int dis, int lck, int mm, int err, int st);
    vec_t v;
    v.gap = gap; v.bcr = bcr; v.clr = clr; v.en = en; v.au = au; v.off = off; v.expBcid = eb;
    v.rst = rst; v.dis = dis; v.lck = lck; v.mm = mm; v.err = err; v.st = st;
    return v;
  endfunction

  task automatic tick();
    @(posedge clkTMR);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    if (exp < 0) return;
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic checkOuts(input vec_t v, input int idx);
    chk("rstBCID", idx, int'(rstBCIDTMR), v.rst);
    chk("dis", idx, int'(disTMR), v.dis);
    chk("locked", idx, int'(lockedTMR), v.lck);
    chk("mismatch", idx, int'(mismatchTMR), v.mm);
    chk("errCount", idx, int'(errCountTMR), v.err);
    chk("state", idx, int'(stateTMR), v.st);
  endtask

  task automatic runVec(input vec_t v, input int idx);
    enableTMR     = v.en[0];
    autoResyncTMR = v.au[0];
    offsetTMR     = v.off[11:0];
    bcrTMR        = 1'b0;
    clrErrTMR     = 1'b0;
    repeat (v.gap) tick();
    bcrTMR    = v.bcr[0];
    clrErrTMR = v.clr[0];
    chk("bcidAtBcr", idx, int'(BCIDTMR), v.expBcid);
    tick();
    bcrTMR    = 1'b0;
    clrErrTMR = 1'b0;
    checkOuts(v, idx);
  endtask

  initial begin
    // gap bcr clr en au off expBcid | rst dis lck mm err st
    vecs[0]  = mk(9,    1, 0, 1, 0, 0,    X,    0, 0, 0, 0, 0,   2);
    vecs[1]  = mk(0,    0, 0, 1, 0, 0,    X,    1, 0, 1, 0, 0,   2);
    vecs[2]  = mk(3562, 1, 0, 1, 0, 0,    3562, 1, 0, 1, 0, 0,   2);
    vecs[3]  = mk(3563, 1, 0, 1, 0, 0,    3562, 1, 0, 1, 0, 0,   2);
    vecs[4]  = mk(0,    0, 0, 0, 0, 0,    X,    1, 1, 0, 0, 0,   0);
    vecs[5]  = mk(0,    0, 0, 1, 0, 5,    X,    1, 0, 0, 0, 0,   1);
    vecs[6]  = mk(2,    1, 0, 1, 0, 5,    X,    0, 0, 0, 0, 0,   2);
    vecs[7]  = mk(3562, 1, 0, 1, 0, 5,    2,    1, 0, 1, 1, 1,   2);
    vecs[8]  = mk(3562, 1, 0, 1, 0, 5,    1,    1, 0, 1, 1, 2,   2);
    vecs[9]  = mk(3562, 1, 0, 1, 0, 5,    0,    1, 0, 0, 1, 3,   3);
    vecs[10] = mk(0,    0, 0, 1, 0, 5,    X,    1, 0, 0, 0, 3,   3);
    vecs[11] = mk(0,    1, 0, 1, 0, 5,    X,    1, 0, 0, 0, 3,   3);
    vecs[12] = mk(0,    0, 1, 1, 0, 5,    X,    1, 0, 0, 0, 0,   1);
    vecs[13] = mk(2,    1, 0, 1, 1, 5,    X,    0, 0, 0, 0, 0,   2);
    vecs[14] = mk(3562, 1, 0, 1, 1, 5,    2,    1, 0, 1, 1, 1,   2);
    vecs[15] = mk(3562, 1, 0, 1, 1, 5,    1,    1, 0, 1, 1, 2,   2);
    vecs[16] = mk(3562, 1, 0, 1, 1, 5,    0,    0, 0, X, 1, 3,   2);
    vecs[17] = mk(3563, 1, 0, 1, 1, 5,    3,    1, 0, 1, 0, 3,   2);
    vecs[18] = mk(0,    0, 0, 0, 1, 5,    X,    1, 1, 0, 0, 3,   0);
    vecs[19] = mk(0,    0, 0, 1, 1, 5,    X,    1, 0, 0, 0, 3,   1);
    vecs[20] = mk(2,    1, 0, 1, 1, 5,    X,    0, 0, 0, 0, 3,   2);
    vecs[21] = mk(1,    1, 0, 1, 1, 5,    X,    0, 0, X, 0, 3,   2);
    vecs[22] = mk(0,    0, 0, 1, 1, 5,    X,    1, 0, 1, 0, 3,   2);
    vecs[23] = mk(0,    0, 0, 0, 1, 5,    X,    1, 1, 0, 0, 255, 0);
    vecs[24] = mk(0,    0, 0, 1, 1, 4000, X,    1, 0, 0, 0, 255, 1);
    vecs[25] = mk(2,    1, 0, 1, 1, 4000, X,    1, 0, 0, 0, 255, 1);
    vecs[26] = mk(0,    0, 0, 1, 1, 4000, X,    1, 0, 0, 0, 255, 1);
    vecs[27] = mk(0,    0, 0, 0, 1, 5,    X,    1, 1, 0, 0, 255, 0);
    vecs[28] = mk(0,    0, 0, 1, 1, 5,    X,    1, 0, 0, 0, 255, 1);
    vecs[29] = mk(0,    1, 0, 0, 1, 5,    X,    1, 1, 0, 0, 255, 0);
    vecs[30] = mk(0,    0, 0, 1, 1, 5,    X,    1, 0, 0, 0, 255, 1);
    vecs[31] = mk(2,    1, 0, 1, 1, 5,    X,    0, 0, 0, 0, 255, 2);
    vecs[32] = mk(3,    1, 1, 1, 1, 5,    7,    1, 0, 1, 1, 0,   2);

    resetTMR = 1'b0; enableTMR = 1'b0; autoResyncTMR = 1'b0;
    bcrTMR = 1'b0; clrErrTMR = 1'b0; offsetTMR = 12'd0;
    repeat (3) tick();
    checkOuts(mk(0, 0, 0, 0, 0, 0, X, 1, 1, 0, 0, 0, 0), -1);
    resetTMR = 1'b1;

    for (int i = 0; i < SPLIT; i++) runVec(vecs[i], i);

    // Drive the error counter into saturation with closely spaced failing checks.
    autoResyncTMR = 1'b1;
    for (int i = 0; i < 299; i++) begin
      repeat (3) tick();
      bcrTMR = 1'b1;
      tick();
      bcrTMR = 1'b0;
    end
    chk("errCountSat", 100, int'(errCountTMR), 255);
    repeat (3) tick();
    bcrTMR = 1'b1;
    tick();
    bcrTMR = 1'b0;
    chk("mismatchAtSat", 101, int'(mismatchTMR), 1);
    chk("errCountHold", 101, int'(errCountTMR), 255);

    for (int i = SPLIT; i < NVEC; i++) runVec(vecs[i], i);

    // Asynchronous reset while the load pulse is low.
    enableTMR = 1'b0;
    tick();
    enableTMR = 1'b1;
    tick();
    bcrTMR = 1'b1;
    tick();
    bcrTMR = 1'b0;
    chk("pulseBeforeReset", 200, int'(rstBCIDTMR), 0);
    resetTMR = 1'b0;
    #1;
    chk("rstBCIDAsync", 201, int'(rstBCIDTMR), 1);
    chk("disAsync", 201, int'(disTMR), 1);
    chk("stateAsync", 201, int'(stateTMR), 0);
    chk("errAsync", 201, int'(errCountTMR), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcid_sync_controller.md
Name: bcid_sync_controller

Overview:
- Sequences the 12-bit BCID counter (0..3563, 3564 BCs per orbit).
- Converts decoded BC-reset (BCR) fast-command strobes into the counter's active-low one-cycle reset and drives its disable.
- Checks at every later BCR that the counter is orbit-aligned.
- Counts misalignments and re-synchronises automatically or on request.
- Sits between the fast-command decoder and the BCID counter in the readout clock domain.

Parameters:
- MAX_BCID, 3563, last BCID of the orbit; orbit length is MAX_BCID+1.
- ERR_THRESH, 3, consecutive mismatches that declare loss of lock (1..15).
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clkTMR  in  1  40 MHz BC clock
- resetTMR  in  1  asynchronous, active-low reset
- enableTMR  in  1  run enable; 0 holds the counter disabled
- autoResyncTMR  in  1  1: re-sync automatically on loss of lock
- bcrTMR  in  1  BC-reset strobe, active-high, one cycle
- clrErrTMR  in  1  clears the error counter; leaves LOST
- offsetTMR  in  12  BCID load value, static while enabled
- BCIDTMR  in  12  live BCID counter value (feedback)
- rstBCIDTMR  out  1  to counter, active-low one-cycle load pulse
- disTMR  out  1  to counter, 1 = hold
- lockedTMR  out  1  alignment confirmed
- mismatchTMR  out  1  one-cycle pulse per failed check
- errCountTMR  out  ERR_CNT_W  saturating mismatch count
- stateTMR  out  2  current state encoding

Behaviour:
- Clock, reset and output timing
  - Single clock clkTMR; resetTMR is asynchronous and active-low.
  - All outputs are registered.
  - Reset values: rstBCIDTMR=1, disTMR=1, lockedTMR=0, mismatchTMR=0, errCountTMR=0, stateTMR=DISABLED, consecutive-mismatch count=0, settle=0.
- States: DISABLED=0, ARM=1, LOCKED=2, LOST=3.
  - DISABLED: disTMR=1. Go to ARM when enableTMR=1.
  - ARM: disTMR=0, lockedTMR=0. First bcrTMR issues a resync and goes to LOCKED.
  - LOCKED: lockedTMR=1 from the cycle after the resync pulse ends. Each bcrTMR outside the settle window is a check.
  - LOST: lockedTMR=0, disTMR=0, counter free-runs. bcrTMR is ignored; clrErrTMR goes to ARM.
- enableTMR=0 in any state
  - DISABLED on the next cycle, disTMR=1.
  - Any pending resync is cancelled and the consecutive count cleared.
  - errCountTMR is kept.
- Resync: bcrTMR high in cycle n gives rstBCIDTMR=0 in cycle n+1 only; the counter holds offsetTMR from cycle n+2.
- Settle window: cycles n+1 and n+2. A bcrTMR in this window is treated as a fresh resync: new pulse, no check, no error.
- Expected value E at a check: (offsetTMR + MAX_BCID - 1) mod (MAX_BCID+1).
  - With the defaults, E = offset-2 if offset>=2, else offset+3562.
  - Compute with 13-bit intermediate arithmetic.
- Check result
  - Match (BCIDTMR==E in the bcrTMR cycle): consecutive count cleared, no pulse.
  - Mismatch: mismatchTMR=1 in cycle n+1, errCountTMR increments and saturates at all-ones, consecutive count increments.
- Loss of lock: when the consecutive count reaches ERR_THRESH.
  - autoResyncTMR=1: the same bcrTMR also issues a resync, the consecutive count clears, state stays LOCKED.
  - autoResyncTMR=0: go to LOST.
- clrErrTMR
  - Zeroes errCountTMR the next cycle.
  - If clrErrTMR and a mismatch occur in the same cycle, clear wins over increment; mismatchTMR still pulses.
  - clrErrTMR with bcrTMR in LOST: go to ARM; that bcrTMR is not acted on.
- Invalid offset (offsetTMR > MAX_BCID): no resync is ever issued and the block stays in ARM.
- Async reset mid-pulse: rstBCIDTMR returns to 1 immediately.

Test Plan:
- Reset, enable=1, offset=0, bcr at cycle 10 -> rstBCID low only in cycle 11; state LOCKED; locked=1 from cycle 12.
- Continue with bcr every 3564 cycles -> BCIDTMR=3562 at each bcr; mismatch never asserted; errCount=0.
- offset=5, bcr period 3563 (one short) -> mismatch pulse at each check; errCount 1,2,3.
  - autoResync=0: state LOST after the 3rd mismatch, locked=0.
  - Then clrErr -> errCount=0, state ARM.
- Same as above with autoResync=1 -> at the 3rd mismatch rstBCID pulses one cycle after that bcr; state stays LOCKED; the next correctly spaced bcr sees BCIDTMR=3.
- bcr at n and again at n+2 -> two reset pulses (n+1, n+3); no mismatch; errCount unchanged.
- errCount forced to 255 by repeated mismatches -> stays 255.
  - enable=0 mid-orbit -> dis=1 next cycle, errCount still 255.
  - offset=4000 with bcr -> no rstBCID, state ARM.
